bus_split_serializer: RTL

- Parametrised successor to the fixed 8-to-2×4 bus splitter.
- Accepts one IN_W-bit word and emits it as NCHUNK = IN_W/OUT_W consecutive OUT_W-bit chunks on a valid/ready stream.
- Chunk order is selectable.
- Sits between wide producers (e.g. byte/word registers) and narrow consumers (nibble/bit-serial links, narrow buses).

---
 rtl/bus_split_serializer.sv | 99 +++++++++
 1 files changed

// File: rtl/bus_split_serializer.sv
// Wide-to-narrow stream serializer: accepts an IN_W-bit word and emits it as
// IN_W/OUT_W consecutive OUT_W-bit chunks on a valid/ready output stream.
module bus_split_serializer #(
    parameter  int IN_W      = 8,
    parameter  int OUT_W     = 4,
    parameter  bit LSB_FIRST = 1'b1,
    localparam int NCHUNK    = IN_W / OUT_W,
    localparam int IDX_W     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [IDX_W-1:0] out_index,
    output logic             busy
);

    if (OUT_W < 1 || OUT_W > IN_W || (IN_W % OUT_W) != 0) begin : g_bad_params
        $error("bus_split_serializer: IN_W must be a positive multiple of OUT_W");
    end

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t           state, state_next;
    logic [IN_W-1:0]  word, word_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic [OUT_W-1:0] data, data_next;
    logic             accept;

    function automatic logic [OUT_W-1:0] chunk_of(input logic [IN_W-1:0] w,
                                                  input logic [IDX_W-1:0] i);
        int              k;
        logic [IN_W-1:0] shifted;
        k       = LSB_FIRST ? int'(i) : (NCHUNK - 1 - int'(i));
        shifted = w >> (k * OUT_W);
        return shifted[OUT_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            word  <= '0;
            idx   <= '0;
            data  <= '0;
        end else begin
            state <= state_next;
            word  <= word_next;
            idx   <= idx_next;
            data  <= data_next;
        end
    end

    // The output chunk is registered alongside the index so out_data holds its
    // last value once the block drops back to IDLE.
    always_comb begin
        state_next = state;
        word_next  = word;
        idx_next   = idx;
        data_next  = data;
        out_valid  = (state == SEND);
        out_last   = out_valid && (idx == LAST_IDX);
        in_ready   = !flush && (!out_valid || (out_ready && out_last));
        accept     = in_valid && in_ready;

        if (flush) begin
            state_next = IDLE;
            idx_next   = '0;
        end else if (accept) begin
            state_next = SEND;
            word_next  = in_data;
            idx_next   = '0;
            data_next  = chunk_of(in_data, '0);
        end else if (out_valid && out_ready) begin
            if (out_last) begin
                state_next = IDLE;
                idx_next   = '0;
            end else begin
                idx_next  = idx + IDX_W'(1);
                data_next = chunk_of(word, idx + IDX_W'(1));
            end
        end
    end

    assign out_data  = data;
    assign out_index = idx;
    assign busy      = out_valid;

endmodule
